sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Single-clock, parametrised FIFO; same-domain successor to the CDC FIFO for CPU-side buffering.
//  Adds occupancy count, programmable almost-full/almost-empty, flush, sticky overflow/underflow
//  error flags, and a selectable read mode: first-word-fall-through or registered.
//  Feeds DMA/bus request queues where both producer and consumer run on clk.
// PARAMETERS
//  FIFO_DATA_BITS  49  width of one entry
//  FIFO_DEPTH_PTR  4   log2(depth); DEPTH = 2**FIFO_DEPTH_PTR, legal >= 1
//  AFULL_TH        12  almost_full when count >= AFULL_TH; legal 1..DEPTH
//  AEMPTY_TH       2   almost_empty when count <= AEMPTY_TH; legal 0..DEPTH-1
//  FWFT            1   1: first-word-fall-through read; 0: registered read, 1-cycle latency
// PORTS
//  clk           in   1                 single clock, rising edge
//  rst           in   1                 asynchronous, active-high reset
//  flush         in   1                 synchronous clear of contents, pointers and flags
//  wr_en         in   1                 write request
//  w_data        in   FIFO_DATA_BITS    write data
//  rd_en         in   1                 read request / pop
//  r_data        out  FIFO_DATA_BITS    read data (see BEHAVIOUR)
//  r_valid       out  1                 FWFT=1: equals not_empty; FWFT=0: 1-cycle pulse with r_data
//  not_empty     out  1                 count != 0
//  not_full      out  1                 count != DEPTH
//  almost_full   out  1                 count >= AFULL_TH
//  almost_empty  out  1                 count <= AEMPTY_TH
//  count         out  FIFO_DEPTH_PTR+1  current occupancy, 0..DEPTH
//  overflow      out  1                 sticky: a write was rejected
//  underflow     out  1                 sticky: a read hit an empty FIFO
// BEHAVIOUR
//  Reset values: count=0, not_empty=0, not_full=1, almost_empty=1, almost_full=0, r_valid=0,
//   r_data=0, overflow=0, underflow=0. Pointers are reset to 0; storage is not reset.
//  Pointers: w_ptr and r_ptr are FIFO_DEPTH_PTR+1-bit binary counters. They wrap modulo 2*DEPTH.
//   The address is the low FIFO_DEPTH_PTR bits. count is a separate register, not a pointer difference.
//  rd_acc = rd_en && not_empty.
//  wr_acc = wr_en && (not_full || rd_acc). At full, a write is accepted only when a read is
//   accepted in the same cycle.
//  Empty plus wr_en plus rd_en in one cycle: the write is accepted and the read is rejected
//   (underflow sets). There is no write-to-read bypass.
//  count update: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
//  All flags decode combinationally from the count register, so they change the cycle after the
//   accepting edge. Write-to-not_empty latency is 1 cycle.
//  FWFT=1: r_data = mem[r_addr] when not_empty, else 0. rd_acc pops the head, and the next entry
//   appears after the edge.
//  FWFT=0: on rd_acc, r_data <= mem[r_addr] and r_valid <= 1. Otherwise r_valid <= 0 and r_data holds.
//  overflow sets on wr_en && !wr_acc. underflow sets on rd_en && !not_empty. Both stay set until
//   rst or flush.
//  flush has priority over wr_en/rd_en in the same cycle. It zeroes pointers, count, overflow,
//   underflow and r_valid. r_data holds in FWFT=0 mode.
//  rst asserted mid-transfer: the FIFO returns immediately to reset values. Any in-flight write is lost.
//  Elaboration: $error if AFULL_TH or AEMPTY_TH is outside its legal range.
// STRUCTURE
//  fifo_pkg: FIFO_DATA_BITS/FIFO_DEPTH_PTR defaults, typedef fifo_cnt_t, parameter-check function.
//  Sub-module fifo_mem: DEPTH x FIFO_DATA_BITS array with synchronous write and asynchronous read.
//   The FWFT=0 output register lives in the top, not in fifo_mem.
//  Top holds the pointers, count, flag decode and sticky error registers.
// TESTING
//  1. Defaults, FWFT=1: write 16 entries 0..15, one per cycle, with no read.
//     -> count=16, not_full=0, almost_full set after the 12th write, overflow=0.
//     Then read 16: r_data=0..15 in order; almost_empty rises at count=2; not_empty=0 at the end.
//  2. Full FIFO, wr_en=rd_en=1 for 5 cycles with data 100..104.
//     -> count stays 16, overflow=0, reads return 0..4. Later reads continue 5..15 then 100..104.
//  3. Empty FIFO, wr_en=rd_en=1 with data 0xAB.
//     -> count=1, underflow=1. Next cycle r_data=0xAB and not_empty=1.
//  4. FWFT=0: write 3,7; assert rd_en for 1 cycle.
//     -> next cycle r_valid=1 and r_data=3. Following cycle r_valid=0 and r_data holds 3.
//  5. Full FIFO plus an extra write, so overflow=1; then flush together with wr_en.
//     -> count=0, overflow=0, not_empty=0. The concurrent write is dropped.
//  6. Pointer wrap: 40 cycles of interleaved write/read of a running counter.
//     -> data is in order with no loss. Also assert rst mid-sequence: every output returns to its
//     reset value asynchronously.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared defaults, occupancy type and threshold sanity check for the
// single-clock flagged FIFO.
package fifo_pkg;

  localparam int DEF_DATA_BITS = 49;
  localparam int DEF_DEPTH_PTR = 4;

  // Occupancy counter sized for the default depth (0..DEPTH inclusive).
  typedef logic [DEF_DEPTH_PTR:0] fifo_cnt_t;

  // True when both flag thresholds sit inside their usable ranges.
  function automatic bit thresholds_ok(input int depth_ptr, input int afull_th,
                                       input int aempty_th);
    int depth;
    depth = 1 << depth_ptr;
    return (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port, no reset.
module fifo_mem #(
  parameter int DATA_BITS = 49,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] w_addr,
  input  logic [DATA_BITS-1:0] w_data,
  input  logic [ADDR_BITS-1:0] r_addr,
  output logic [DATA_BITS-1:0] r_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Store the incoming word at the write address on an accepted write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// flush, sticky overflow/underflow and a choice of FWFT or registered read.
module sync_fifo_flags
  import fifo_pkg::*;
#(
  parameter int FIFO_DATA_BITS = DEF_DATA_BITS,
  parameter int FIFO_DEPTH_PTR = DEF_DEPTH_PTR,
  parameter int AFULL_TH       = 12,
  parameter int AEMPTY_TH      = 2,
  parameter bit FWFT           = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      wr_en,
  input  logic [FIFO_DATA_BITS-1:0] w_data,
  input  logic                      rd_en,
  output logic [FIFO_DATA_BITS-1:0] r_data,
  output logic                      r_valid,
  output logic                      not_empty,
  output logic                      not_full,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [FIFO_DEPTH_PTR:0]   count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_PTR;
  localparam logic [FIFO_DEPTH_PTR:0] DEPTH_CNT  = (FIFO_DEPTH_PTR+1)'(DEPTH);
  localparam logic [FIFO_DEPTH_PTR:0] AFULL_CNT  = (FIFO_DEPTH_PTR+1)'(AFULL_TH);
  localparam logic [FIFO_DEPTH_PTR:0] AEMPTY_CNT = (FIFO_DEPTH_PTR+1)'(AEMPTY_TH);

  if (!thresholds_ok(FIFO_DEPTH_PTR, AFULL_TH, AEMPTY_TH)) begin : g_bad_thresholds
    $error("sync_fifo_flags: AFULL_TH or AEMPTY_TH outside legal range");
  end

  logic [FIFO_DEPTH_PTR:0]   w_ptr_q, w_ptr_d;
  logic [FIFO_DEPTH_PTR:0]   r_ptr_q, r_ptr_d;
  logic [FIFO_DEPTH_PTR:0]   count_q, count_d;
  logic                      overflow_q, overflow_d;
  logic                      underflow_q, underflow_d;
  logic                      rd_acc, wr_acc;
  logic [FIFO_DATA_BITS-1:0] mem_rdata;

  assign not_empty    = (count_q != '0);
  assign not_full     = (count_q != DEPTH_CNT);
  assign almost_full  = (count_q >= AFULL_CNT);
  assign almost_empty = (count_q <= AEMPTY_CNT);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A full FIFO still takes a write when a pop frees a slot in the same cycle.
  assign rd_acc = rd_en && not_empty;
  assign wr_acc = wr_en && (not_full || rd_acc);

  fifo_mem #(
    .DATA_BITS(FIFO_DATA_BITS),
    .ADDR_BITS(FIFO_DEPTH_PTR)
  ) u_mem (
    .clk   (clk),
    .wr_en (wr_acc && !flush),
    .w_addr(w_ptr_q[FIFO_DEPTH_PTR-1:0]),
    .w_data(w_data),
    .r_addr(r_ptr_q[FIFO_DEPTH_PTR-1:0]),
    .r_data(mem_rdata)
  );

  // Next pointers, occupancy and sticky errors; flush overrides any transfer.
  always_comb begin
    w_ptr_d     = w_ptr_q;
    r_ptr_d     = r_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
      if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
      if (wr_acc && !rd_acc)      count_d = count_q + 1'b1;
      else if (rd_acc && !wr_acc) count_d = count_q - 1'b1;
      if (wr_en && !wr_acc)       overflow_d  = 1'b1;
      if (rd_en && !not_empty)    underflow_d = 1'b1;
    end
  end

  // Pointer, count and error state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_ptr_q     <= '0;
      r_ptr_q     <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      w_ptr_q     <= w_ptr_d;
      r_ptr_q     <= r_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  if (FWFT) begin : g_fwft
    assign r_data  = not_empty ? mem_rdata : '0;
    assign r_valid = not_empty;
  end else begin : g_registered
    logic [FIFO_DATA_BITS-1:0] r_data_q, r_data_d;
    logic                      r_valid_q, r_valid_d;

    // Capture the head on a pop; data holds otherwise, valid is a one-cycle pulse.
    always_comb begin
      r_data_d  = r_data_q;
      r_valid_d = 1'b0;
      if (!flush && rd_acc) begin
        r_data_d  = mem_rdata;
        r_valid_d = 1'b1;
      end
    end

    // Registered read output stage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_data_q  <= r_data_d;
        r_valid_q <= r_valid_d;
      end
    end

    assign r_data  = r_data_q;
    assign r_valid = r_valid_q;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench: an FWFT and a registered-read instance share the same
// stimulus and are compared each cycle against a queue-based model.
module tb_sync_fifo_flags;

  localparam int DW    = 49;
  localparam int PW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] w_data = '0;

  logic [DW-1:0] r_data_f, r_data_r;
  logic          r_valid_f, r_valid_r;
  logic          not_empty_f, not_full_f, almost_full_f, almost_empty_f;
  logic          not_empty_r, not_full_r, almost_full_r, almost_empty_r;
  logic [PW:0]   count_f, count_r;
  logic          overflow_f, underflow_f, overflow_r, underflow_r;

  sync_fifo_flags #(.FWFT(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .w_data(w_data),
    .rd_en(rd_en), .r_data(r_data_f), .r_valid(r_valid_f),
    .not_empty(not_empty_f), .not_full(not_full_f),
    .almost_full(almost_full_f), .almost_empty(almost_empty_f),
    .count(count_f), .overflow(overflow_f), .underflow(underflow_f)
  );

  sync_fifo_flags #(.FWFT(1'b0)) dut_reg (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .w_data(w_data),
    .rd_en(rd_en), .r_data(r_data_r), .r_valid(r_valid_r),
    .not_empty(not_empty_r), .not_full(not_full_r),
    .almost_full(almost_full_r), .almost_empty(almost_empty_r),
    .count(count_r), .overflow(overflow_r), .underflow(underflow_r)
  );

  always #5 clk = ~clk;

  // Reference model: contents as a queue, sticky errors, registered-read output.
  logic [DW-1:0] q[$];
  bit            m_ovf, m_udf;
  bit            m_rv;
  logic [DW-1:0] m_rdata;

  int checks = 0;
  int fails  = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    q.delete();
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
    m_rv    = 1'b0;
    m_rdata = '0;
  endtask

  // Apply one clock's worth of request rules to the model.
  task automatic modelEdge(input bit wr, input logic [DW-1:0] wd, input bit rd, input bit fl);
    int  n;
    bit  rdok, wrok;
    n    = q.size();
    rdok = rd && (n > 0);
    wrok = wr && ((n < DEPTH) || rdok);
    if (fl) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_rv  = 1'b0;
    end else begin
      if (rd && n == 0) m_udf = 1'b1;
      if (wr && !wrok)  m_ovf = 1'b1;
      m_rv = rdok;
      if (rdok) m_rdata = q.pop_front();
      if (wrok) q.push_back(wd);
    end
  endtask

  task automatic checkOutput(input string tag);
    int            n;
    logic [DW-1:0] head;
    n    = q.size();
    head = (n > 0) ? q[0] : '0;
    checkVal({tag, ".count"},        64'(count_f),        64'(n));
    checkVal({tag, ".not_empty"},    64'(not_empty_f),    64'(n != 0));
    checkVal({tag, ".not_full"},     64'(not_full_f),     64'(n != DEPTH));
    checkVal({tag, ".almost_full"},  64'(almost_full_f),  64'(n >= 12));
    checkVal({tag, ".almost_empty"}, 64'(almost_empty_f), 64'(n <= 2));
    checkVal({tag, ".overflow"},     64'(overflow_f),     64'(m_ovf));
    checkVal({tag, ".underflow"},    64'(underflow_f),    64'(m_udf));
    checkVal({tag, ".r_valid"},      64'(r_valid_f),      64'(n != 0));
    checkVal({tag, ".r_data"},       64'(r_data_f),       64'(head));
    checkVal({tag, ".reg.count"},    64'(count_r),        64'(n));
    checkVal({tag, ".reg.r_valid"},  64'(r_valid_r),      64'(m_rv));
    checkVal({tag, ".reg.r_data"},   64'(r_data_r),       64'(m_rdata));
  endtask

  // Drive one cycle of requests, advance the model at the edge, then check.
  task automatic applyStimulus(input string tag, input bit wr, input logic [DW-1:0] wd,
                               input bit rd, input bit fl);
    wr_en  = wr;
    w_data = wd;
    rd_en  = rd;
    flush  = fl;
    @(posedge clk);
    modelEdge(wr, wd, rd, fl);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    flush = 1'b0;
    checkOutput(tag);
  endtask

  initial begin
    logic [DW-1:0] rnd;
    modelReset();

    rst = 1'b1;
    #12;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_reset");

    for (int i = 0; i < 16; i++) applyStimulus("t1_fill", 1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus("t1_drain", 1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) applyStimulus("t2_fill", 1'b1, DW'(i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)  applyStimulus("t2_wr_rd_full", 1'b1, DW'(100 + i), 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) applyStimulus("t2_drain", 1'b0, '0, 1'b1, 1'b0);

    applyStimulus("t3_empty_wr_rd", 1'b1, DW'(8'hAB), 1'b1, 1'b0);
    applyStimulus("t3_idle", 1'b0, '0, 1'b0, 1'b0);
    applyStimulus("t3_pop", 1'b0, '0, 1'b1, 1'b0);

    applyStimulus("t4_wr3", 1'b1, DW'(3), 1'b0, 1'b0);
    applyStimulus("t4_wr7", 1'b1, DW'(7), 1'b0, 1'b0);
    applyStimulus("t4_rd", 1'b0, '0, 1'b1, 1'b0);
    applyStimulus("t4_hold", 1'b0, '0, 1'b0, 1'b0);
    applyStimulus("t4_rd2", 1'b0, '0, 1'b1, 1'b0);

    for (int i = 0; i < 16; i++) applyStimulus("t5_fill", 1'b1, DW'(200 + i), 1'b0, 1'b0);
    applyStimulus("t5_overflow", 1'b1, DW'(999), 1'b0, 1'b0);
    applyStimulus("t5_flush_wr", 1'b1, DW'(555), 1'b0, 1'b1);
    applyStimulus("t5_after", 1'b0, '0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus("t6_wrap", (i % 2) == 0, DW'(1000 + i), (i % 2) == 1, 1'b0);
      if (i == 25) begin
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("t6_async_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    for (int i = 0; i < 300; i++) begin
      rnd = {$urandom, $urandom};
      applyStimulus("rand", $urandom_range(0, 99) < 55, rnd,
                    $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 3);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
